// File: rtl/line_buffer_pkg.sv
// Constants, state encoding and bank mapping for the circular line buffer.
// Shared by the UART loader and the read-side window scheduler.
package line_buffer_pkg;

  localparam int PIXELS_PER_LINE = 256;
  localparam int LINES_PER_FRAME = 256;
  localparam int NUM_BANKS       = 4;
  localparam int WINDOW_ROWS     = 3;

  localparam int COL_W  = $clog2(PIXELS_PER_LINE);
  // One extra bit so the line count can reach LINES_PER_FRAME itself.
  localparam int LINE_W = $clog2(LINES_PER_FRAME) + 1;
  localparam int BANK_W = $clog2(NUM_BANKS);

  localparam int REFILL_ROWS = LINES_PER_FRAME - NUM_BANKS;
  localparam int OUT_ROWS    = LINES_PER_FRAME - 2;

  typedef logic [BANK_W-1:0] bank_idx_t;
  typedef logic [LINE_W-1:0] line_idx_t;
  typedef logic [COL_W-1:0]  col_idx_t;

  localparam line_idx_t LAST_ROW     = line_idx_t'(OUT_ROWS);
  localparam line_idx_t REFILL_LIMIT = line_idx_t'(REFILL_ROWS);
  localparam line_idx_t FRAME_LINES  = line_idx_t'(LINES_PER_FRAME);
  localparam line_idx_t BANK_CAP     = line_idx_t'(NUM_BANKS);
  localparam col_idx_t  COL_LAST     = col_idx_t'(PIXELS_PER_LINE - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READ    = 2'd1,
    S_RELEASE = 2'd2,
    S_DONE    = 2'd3
  } sched_state_t;

  function automatic bank_idx_t bank_of(input line_idx_t line);
    return bank_idx_t'(line % line_idx_t'(NUM_BANKS));
  endfunction

endpackage

// File: rtl/line_occupancy_counter.sv
// Tracks how many lines the loader has written this frame, whether a full
// 3-row window is resident, and flags writes into an already-full buffer.
module line_occupancy_counter
  import line_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_line_done,
  input  logic              frame_clear,
  input  logic [LINE_W-1:0] row,
  output logic              window_ready,
  output logic              overrun_err
);

  logic [LINE_W-1:0] lines_written_reg;
  logic [LINE_W-1:0] lines_written_next;
  logic [LINE_W-1:0] occupancy;
  logic [LINE_W:0]   rows_needed;
  logic              bank_full;
  logic              overrun_reg;

  // Banks currently held: lines landed minus lines already released.
  assign occupancy    = lines_written_reg - row;
  assign bank_full    = (occupancy == BANK_CAP);
  assign rows_needed  = {1'b0, row} + (LINE_W+1)'(WINDOW_ROWS);
  assign window_ready = ({1'b0, lines_written_reg} >= rows_needed);

  always_comb begin
    lines_written_next = lines_written_reg;
    if (frame_clear) begin
      // A line finishing on the wrap cycle belongs to the next frame.
      lines_written_next = wr_line_done ? LINE_W'(1) : '0;
    end else if (wr_line_done && (lines_written_reg != FRAME_LINES)) begin
      lines_written_next = lines_written_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lines_written_reg <= '0;
      overrun_reg       <= 1'b0;
    end else begin
      lines_written_reg <= lines_written_next;
      if (wr_line_done && bank_full) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign overrun_err = overrun_reg;

endmodule

// File: rtl/line_window_scheduler.sv
// Read-side sequencer for the circular line buffer: walks rows and columns,
// presents a 3-bank window and asks the loader to refill each freed bank.
module line_window_scheduler
  import line_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              wr_line_done,
  input  logic              proc_ready,
  output logic              rd_en,
  output logic [COL_W-1:0]  rd_addr,
  output logic [BANK_W-1:0] bank_top,
  output logic [BANK_W-1:0] bank_mid,
  output logic [BANK_W-1:0] bank_bot,
  output logic              pix_valid,
  output logic [LINE_W-1:0] out_row,
  output logic              refill_req,
  output logic              frame_done,
  output logic              overrun_err,
  output logic              busy
);

  sched_state_t state_reg;
  sched_state_t state_next;

  logic [COL_W-1:0]  col_reg;
  logic [LINE_W-1:0] row_reg;
  logic [LINE_W-1:0] row_inc;

  logic [WINDOW_ROWS-1:0][BANK_W-1:0] bank_sel;
  logic [WINDOW_ROWS-1:0][BANK_W-1:0] bank_reg;

  logic window_ready;
  logic start_row;
  logic rd_issue;
  logic release_row;
  logic frame_clear;
  logic refill_next;
  logic frame_done_next;
  logic busy_next;

  logic             rd_en_reg;
  logic [COL_W-1:0] rd_addr_reg;
  logic             pix_valid_reg;
  logic             refill_req_reg;
  logic             frame_done_reg;
  logic             busy_reg;

  assign row_inc = row_reg + 1'b1;

  line_occupancy_counter u_occupancy (
    .clk          (clk),
    .reset        (reset),
    .wr_line_done (wr_line_done),
    .frame_clear  (frame_clear),
    .row          (row_reg),
    .window_ready (window_ready),
    .overrun_err  (overrun_err)
  );

  // Window tap gi reads line row+gi, which lives in bank (row+gi) mod NUM_BANKS.
  genvar gi;
  generate
    for (gi = 0; gi < WINDOW_ROWS; gi++) begin : g_tap
      assign bank_sel[gi] = bank_of(row_reg + LINE_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (enable && window_ready) begin
          state_next = S_READ;
        end
      end
      S_READ: begin
        if (proc_ready && (col_reg == COL_LAST)) begin
          state_next = S_RELEASE;
        end
      end
      S_RELEASE: begin
        state_next = (row_inc == LAST_ROW) ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Pulse outputs are keyed on the next state so they line up with the state.
  always_comb begin
    start_row       = 1'b0;
    rd_issue        = 1'b0;
    release_row     = 1'b0;
    frame_clear     = 1'b0;
    busy_next       = (state_next != S_IDLE);
    refill_next     = (state_next == S_RELEASE) && (row_reg < REFILL_LIMIT);
    frame_done_next = (state_next == S_DONE);
    case (state_reg)
      S_IDLE:    start_row   = (state_next == S_READ);
      S_READ:    rd_issue    = proc_ready;
      S_RELEASE: release_row = 1'b1;
      S_DONE:    frame_clear = 1'b1;
      default:   start_row   = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_reg        <= '0;
      row_reg        <= '0;
      bank_reg       <= '0;
      rd_en_reg      <= 1'b0;
      rd_addr_reg    <= '0;
      pix_valid_reg  <= 1'b0;
      refill_req_reg <= 1'b0;
      frame_done_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      rd_en_reg      <= rd_issue;
      pix_valid_reg  <= rd_en_reg;
      refill_req_reg <= refill_next;
      frame_done_reg <= frame_done_next;
      busy_reg       <= busy_next;

      if (rd_issue) begin
        rd_addr_reg <= col_reg;
      end

      // The column counter wraps to 0 on the last issue, ready for the next row.
      if (start_row) begin
        col_reg  <= '0;
        bank_reg <= bank_sel;
      end else if (rd_issue) begin
        col_reg <= col_reg + 1'b1;
      end

      if (release_row) begin
        row_reg <= row_inc;
      end else if (frame_clear) begin
        row_reg <= '0;
      end
    end
  end

  assign rd_en      = rd_en_reg;
  assign rd_addr    = rd_addr_reg;
  assign bank_top   = bank_reg[0];
  assign bank_mid   = bank_reg[1];
  assign bank_bot   = bank_reg[2];
  assign pix_valid  = pix_valid_reg;
  assign out_row    = row_reg;
  assign refill_req = refill_req_reg;
  assign frame_done = frame_done_reg;
  assign busy       = busy_reg;

endmodule
